div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider for DIV/DIVU in the execute stage, alongside the ALU.
//  Takes the same rs/rt operands the ALU receives and produces quotient (LO) and remainder (HI)
//  for the HILO register write.
//  Stalls the pipeline while running; a flush cancels it.
// PARAMETERS
//  WIDTH    32   operand/result width; iteration count = WIDTH
//  CNT_W    6    iteration counter width; must hold WIDTH
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  resetn       in   1      asynchronous, active-low reset
//  start        in   1      request divide; sampled only in IDLE
//  signed_div   in   1      1=DIV (two's complement), 0=DIVU
//  cancel       in   1      flush/exception; aborts current operation
//  dividend     in   WIDTH  rs value, captured on accepted start
//  divisor      in   WIDTH  rt value, captured on accepted start
//  div_stall    out  1      (state==IDLE & start & ~cancel) | state==RUN; combinational
//  done         out  1      one-cycle pulse, results valid
//  quotient     out  WIDTH  to LO; held until next done
//  remainder    out  WIDTH  to HI; held until next done
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, counter=0, done=0, quotient=0, remainder=0.
//  States: IDLE -> RUN on start&~cancel; RUN -> DONE when counter reaches WIDTH-1.
//   DONE -> IDLE unconditionally next edge; done=1 only in DONE.
//  Start accept (edge T0): latch |dividend|, |divisor| when signed_div, else raw values.
//   Also latch sign flags qneg=sa^sb and rneg=sa (signed only); clear partial remainder and counter.
//  RUN: one quotient bit per edge, MSB first: shift {rem,quo} left 1, trial subtract divisor.
//   If no borrow: keep difference, set quotient bit 1; else restore, set bit 0.
//   Exactly WIDTH RUN cycles: done is high in the cycle after edge T0+WIDTH; start->done = WIDTH+1 edges (33).
//  Sign fix-up at entry to DONE: quotient negated if qneg; remainder negated if rneg.
//   Remainder sign always follows dividend sign.
//  Divide by zero: no trap; full iteration runs; quotient=all-ones (unsigned magnitude), remainder=dividend.
//   Signed fix-up still applied. Latency unchanged.
//  0x8000_0000 / -1 signed: quotient=0x8000_0000, remainder=0; no overflow flag (MIPS DIV never traps).
//  Outputs quotient/remainder update only on entry to DONE; stable otherwise.
//  start while RUN or DONE: ignored; div_stall still covers RUN.
//   Control must re-present start in a later IDLE cycle.
//  cancel in RUN or DONE: state->IDLE next edge; done suppressed (forced 0 in that cycle); outputs not updated.
//  cancel and start same cycle in IDLE: not accepted; div_stall=0.
//  resetn low mid-RUN: immediate IDLE, outputs cleared; no done.
// STRUCTURE
//  defines2.vh additions: DIV_IDLE=2'b00, DIV_RUN=2'b01, DIV_DONE=2'b10; no other new macros.
//  One sub-module: div_step (combinational, WIDTH): inputs partial rem, quo, divisor.
//   Outputs next rem and next quo for one iteration.
//  Sign handling, counter and FSM stay in div_iter; no multiplier logic here.
// TESTING
//  DIVU 100/7: start T0 -> div_stall high T0..T32; done at cycle 33.
//   quotient=14, remainder=2; done exactly one cycle.
//  DIV -7/2 -> quotient=0xFFFF_FFFD (-3), remainder=0xFFFF_FFFF (-1).
//   DIV 7/-2 -> quotient=-3, remainder=1.
//  DIV 0x8000_0000/0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0.
//   DIVU same operands -> quotient=0, remainder=0x8000_0000.
//  DIVU 0x1234/0 -> quotient=0xFFFF_FFFF, remainder=0x1234 at cycle 33.
//  cancel at cycle 10 -> IDLE next edge; no done pulse; quotient/remainder keep previous values.
//   New start then completes normally.
//  resetn low at cycle 5 -> all outputs 0 asynchronously; start pulse during RUN ignored.
//   Random signed/unsigned sweep vs. $signed / and % model.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative divider.
package div_iter_pkg;

  // Legacy 2-bit state encodings, kept bit-exact with the old defines.
  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'b00;
  localparam div_state_t DIV_RUN  = 2'b01;
  localparam div_state_t DIV_DONE = 2'b10;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // Shifted partial remainder needs one extra bit; the difference always fits in WIDTH.
  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    borrow = (rem_sh < {1'b0, divisor_i});
    diff   = rem_sh[WIDTH-1:0] - divisor_i;
    rem_o  = borrow ? rem_sh[WIDTH-1:0] : diff;
    quo_o  = {quo_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU; quotient to LO, remainder to HI.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic             sa, sb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // FSM, operand capture, iteration and sign fix-up on entry to DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    sa          = signed_div & dividend[WIDTH-1];
    sb          = signed_div & divisor[WIDTH-1];

    case (state_q)
      DIV_IDLE: begin
        if (start && !cancel) begin
          state_d = DIV_RUN;
          quo_d   = sa ? -dividend : dividend;
          dvs_d   = sb ? -divisor  : divisor;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = sa ^ sb;
          rneg_d  = sa;
        end
      end
      DIV_RUN: begin
        if (cancel) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d     = DIV_DONE;
            quotient_d  = qneg_q ? -step_quo : step_quo;
            remainder_d = rneg_q ? -step_rem : step_rem;
          end
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // Stall and done are combinational so a flush suppresses done in the same cycle.
  always_comb begin
    div_stall = ((state_q == DIV_IDLE) && start && !cancel) || (state_q == DIV_RUN);
    done      = (state_q == DIV_DONE) && !cancel;
    quotient  = quotient_q;
    remainder = remainder_q;
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed/unsigned results, cancel, reset, sweep.
module tb_div_iter;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_stall;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total = 0;
  int bad   = 0;

  div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .cancel     (cancel),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_stall  (div_stall),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one accepted start, then wait (bounded) for done; lat = edges after the accept edge.
  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic timed_out);
    @(negedge clk);
    start = 1'b1; signed_div = sd; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    timed_out = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; cancel = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL reset_quo got=%h exp=%h", quotient, 32'h0); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL reset_rem got=%h exp=%h", remainder, 32'h0); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (div_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", div_stall); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_timing();
    int stall_errs;
    int done_errs;
    stall_errs = 0;
    done_errs  = 0;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
    #1;
    total++; if (div_stall !== 1'b1) begin bad++; $display("FAIL stall_at_start got=%b exp=1", div_stall); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    // 32 RUN cycles follow the accept edge.
    for (int i = 0; i < 32; i++) begin
      if (div_stall !== 1'b1) stall_errs++;
      if (done !== 1'b0) done_errs++;
      @(posedge clk);
      @(negedge clk);
    end
    total++; if (stall_errs != 0) begin bad++; $display("FAIL stall_run got=%0d_bad_cycles exp=0", stall_errs); end
    total++; if (done_errs != 0) begin bad++; $display("FAIL early_done got=%0d_bad_cycles exp=0", done_errs); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_at_33 got=%b exp=1", done); end
    total++; if (div_stall !== 1'b0) begin bad++; $display("FAIL stall_in_done got=%b exp=0", div_stall); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL divu_100_7_quo got=%h exp=%h", quotient, 32'd14); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL divu_100_7_rem got=%h exp=%h", remainder, 32'd2); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL quo_held got=%h exp=%h", quotient, 32'd14); end
  endtask

  task automatic test_signed();
    int lat;
    logic to;
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic        vs [5];
    logic [31:0] eq [5];
    logic [31:0] er [5];
    va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;          vs[0] = 1'b1; eq[0] = 32'hFFFF_FFFD; er[0] = 32'hFFFF_FFFF;
    va[1] = 32'd7;          vb[1] = 32'hFFFF_FFFE; vs[1] = 1'b1; eq[1] = 32'hFFFF_FFFD; er[1] = 32'd1;
    va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF; vs[2] = 1'b1; eq[2] = 32'h8000_0000; er[2] = 32'h0;
    va[3] = 32'h8000_0000; vb[3] = 32'hFFFF_FFFF; vs[3] = 1'b0; eq[3] = 32'h0;         er[3] = 32'h8000_0000;
    va[4] = 32'hFFFF_FFF9; vb[4] = 32'hFFFF_FFFE; vs[4] = 1'b1; eq[4] = 32'd3;         er[4] = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      do_div(vs[i], va[i], vb[i], lat, to);
      total++; if (to || lat != 32) begin bad++; $display("FAIL signed_lat[%0d] got=%0d exp=32", i, lat); end
      total++; if (quotient !== eq[i]) begin bad++; $display("FAIL signed_quo[%0d] got=%h exp=%h", i, quotient, eq[i]); end
      total++; if (remainder !== er[i]) begin bad++; $display("FAIL signed_rem[%0d] got=%h exp=%h", i, remainder, er[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic to;
    do_div(1'b0, 32'h1234, 32'h0, lat, to);
    total++; if (to || lat != 32) begin bad++; $display("FAIL divz_lat got=%0d exp=32", lat); end
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_quo got=%h exp=%h", quotient, 32'hFFFF_FFFF); end
    total++; if (remainder !== 32'h1234) begin bad++; $display("FAIL divz_rem got=%h exp=%h", remainder, 32'h1234); end
    // Signed -7/0: magnitude all-ones negated to 1, remainder follows dividend.
    do_div(1'b1, 32'hFFFF_FFF9, 32'h0, lat, to);
    total++; if (quotient !== 32'h1) begin bad++; $display("FAIL divz_s_quo got=%h exp=%h", quotient, 32'h1); end
    total++; if (remainder !== 32'hFFFF_FFF9) begin bad++; $display("FAIL divz_s_rem got=%h exp=%h", remainder, 32'hFFFF_FFF9); end
  endtask

  task automatic test_cancel();
    int lat;
    logic to;
    int spurious;
    do_div(1'b0, 32'd100, 32'd7, lat, to);
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    #1;
    total++; if (div_stall !== 1'b1) begin bad++; $display("FAIL cancel_stall_run got=%b exp=1", div_stall); end
    @(negedge clk);
    cancel = 1'b0;
    #1;
    total++; if (div_stall !== 1'b0) begin bad++; $display("FAIL cancel_to_idle got=%b exp=0", div_stall); end
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL cancel_no_done got=%0d exp=0", spurious); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL cancel_quo_kept got=%h exp=%h", quotient, 32'd14); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL cancel_rem_kept got=%h exp=%h", remainder, 32'd2); end
    // Start with cancel in IDLE is not accepted.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd2;
    #1;
    total++; if (div_stall !== 1'b0) begin bad++; $display("FAIL start_cancel_stall got=%b exp=0", div_stall); end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || div_stall) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL start_cancel_ignored got=%0d exp=0", spurious); end
    do_div(1'b0, 32'd50, 32'd3, lat, to);
    total++; if (to || lat != 32) begin bad++; $display("FAIL after_cancel_lat got=%0d exp=32", lat); end
    total++; if (quotient !== 32'd16) begin bad++; $display("FAIL after_cancel_quo got=%h exp=%h", quotient, 32'd16); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL after_cancel_rem got=%h exp=%h", remainder, 32'd2); end
  endtask

  task automatic test_start_during_run();
    int spurious;
    int lat;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 32'd5; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int i = 6; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    total++; if (lat != 32) begin bad++; $display("FAIL run_start_lat got=%0d exp=32", lat); end
    total++; if (quotient !== 32'd111) begin bad++; $display("FAIL run_start_quo got=%h exp=%h", quotient, 32'd111); end
    total++; if (remainder !== 32'd1) begin bad++; $display("FAIL run_start_rem got=%h exp=%h", remainder, 32'd1); end
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL run_start_second_done got=%0d exp=0", spurious); end
  endtask

  task automatic test_reset_midrun();
    int spurious;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd77; divisor = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL rst_mid_quo got=%h exp=%h", quotient, 32'h0); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL rst_mid_rem got=%h exp=%h", remainder, 32'h0); end
    total++; if (div_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", div_stall); end
    @(negedge clk);
    resetn = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d exp=0", spurious); end
  endtask

  task automatic test_sweep();
    int lat;
    logic to;
    logic        sd;
    logic [31:0] a, b, eq, er;
    logic signed [31:0] sa, sb;
    for (int i = 0; i < 16; i++) begin
      sd = i[0];
      a  = $urandom;
      b  = (i < 8) ? ($urandom & 32'h0000_FFFF) : $urandom;
      if (i[1]) b = -b;
      if (b == 32'h0) b = 32'd3;
      if (sd && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      if (sd) begin
        sa = a; sb = b;
        eq = sa / sb;
        er = sa % sb;
      end else begin
        eq = a / b;
        er = a % b;
      end
      do_div(sd, a, b, lat, to);
      total++; if (to || quotient !== eq) begin bad++; $display("FAIL sweep_quo[%0d] a=%h b=%h s=%b got=%h exp=%h", i, a, b, sd, quotient, eq); end
      total++; if (remainder !== er) begin bad++; $display("FAIL sweep_rem[%0d] a=%h b=%h s=%b got=%h exp=%h", i, a, b, sd, remainder, er); end
    end
  endtask

  initial begin
    test_reset();
    test_divu_timing();
    test_signed();
    test_div_zero();
    test_cancel();
    test_start_during_run();
    test_reset_midrun();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
